rd_side_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 34 +++
 rtl/gray2bin_conv.sv | 18 +
 rtl/rd_side_ctrl.sv | 129 ++++++++++++
 tb/tb_rd_side_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: flush FSM encoding and gray/binary pointer helpers.
package fifo_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_FLUSH_SKIP = 2'd1;
    localparam logic [1:0] ST_FLUSH_ACK  = 2'd2;

    typedef enum logic [1:0] {
        StRun       = ST_RUN,
        StFlushSkip = ST_FLUSH_SKIP,
        StFlushAck  = ST_FLUSH_ACK
    } flush_state_e;

    localparam int unsigned MaxW = 32;

    function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits at or above width are treated as zero so a stale upper field cannot leak in.
    function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g,
                                                 input int unsigned    width);
        logic [MaxW-1:0] gm;
        logic [MaxW-1:0] b;
        for (int j = 0; j < int'(MaxW); j++) begin
            gm[j] = (j < int'(width)) ? g[j] : 1'b0;
        end
        for (int i = 0; i < int'(MaxW); i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational gray-to-binary pointer converter, shared by both FIFO clock domains.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);

    logic [MaxW-1:0] bin_full;

    always_comb begin
        bin_full = gray2bin(MaxW'(gray), width);
        bin      = bin_full[width-1:0];
    end

endmodule

// File: rtl/rd_side_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, status flags, pop strobes and
// the flush handshake toward the write domain.
module rd_side_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned depth     = 7,
    parameter int unsigned ae_thresh = 2
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic [depth:0]   w2rsync_ff2,
    input  logic             syn_flush,
    input  logic             rd_req,
    output logic             mem_rd_en,
    output logic [depth-1:0] raddr,
    output logic             rd_data_valid,
    output logic [depth:0]   rptr,
    output logic             empty,
    output logic             almost_empty,
    output logic [depth:0]   rd_count,
    output logic             flush_ack,
    output logic             busy_flush
);

    localparam int unsigned PtrW = depth + 1;

    flush_state_e    state_q, state_d;
    logic [PtrW-1:0] rbin_q, rbin_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] cnt_q, cnt_d;
    logic            empty_q, empty_d;
    logic            ae_q, ae_d;
    logic            ack_q, ack_d;
    logic            valid_q;
    logic            syn_flush_q;
    logic [PtrW-1:0] wbin;
    logic [MaxW-1:0] gray_full;
    logic            flush_rise;
    logic            pop;

    gray2bin_conv #(
        .width (PtrW)
    ) u_wptr_conv (
        .gray (w2rsync_ff2),
        .bin  (wbin)
    );

    // A flush edge wins over a pop requested in the same cycle.
    assign flush_rise = syn_flush & ~syn_flush_q;
    assign pop        = rd_req & ~empty_q & (state_q == StRun) & ~flush_rise;

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        rbin_d    = rbin_q + PtrW'(pop);
        gray_full = bin2gray(MaxW'(rbin_d));
        rptr_d    = gray_full[PtrW-1:0];
        empty_d   = (rptr_d == w2rsync_ff2);
        cnt_d     = wbin - rbin_d;
        ae_d      = (cnt_d <= PtrW'(ae_thresh));

        unique case (state_q)
            StRun: begin
                if (flush_rise) begin
                    state_d = StFlushSkip;
                end
            end
            StFlushSkip: begin
                rbin_d  = wbin;
                rptr_d  = w2rsync_ff2;
                empty_d = 1'b1;
                cnt_d   = '0;
                ae_d    = 1'b1;
                ack_d   = 1'b1;
                state_d = StFlushAck;
            end
            StFlushAck: begin
                // Keep swallowing writes until the write side drops its request.
                rbin_d  = wbin;
                rptr_d  = w2rsync_ff2;
                empty_d = 1'b1;
                cnt_d   = '0;
                ae_d    = 1'b1;
                if (!syn_flush) begin
                    ack_d   = 1'b0;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            rbin_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            syn_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rbin_q      <= rbin_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            ack_q       <= ack_d;
            valid_q     <= pop;
            syn_flush_q <= syn_flush;
        end
    end

    assign mem_rd_en     = pop;
    assign raddr         = rbin_q[depth-1:0];
    assign rd_data_valid = valid_q;
    assign rptr          = rptr_q;
    assign empty         = empty_q;
    assign almost_empty  = ae_q;
    assign rd_count      = cnt_q;
    assign flush_ack     = ack_q;
    assign busy_flush    = (state_q != StRun);

endmodule

// File: tb/tb_rd_side_ctrl.sv
// Self-checking bench for rd_side_ctrl: scoreboarded read addresses plus directed flag checks.
module tb_rd_side_ctrl;

    logic       clk_out = 1'b0;
    logic       reset;
    logic [7:0] w2rsync_ff2;
    logic       syn_flush;
    logic       rd_req;
    logic       mem_rd_en;
    logic [6:0] raddr;
    logic       rd_data_valid;
    logic [7:0] rptr;
    logic       empty;
    logic       almost_empty;
    logic [7:0] rd_count;
    logic       flush_ack;
    logic       busy_flush;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] exp_q[$];
    logic       last_pop = 1'b0;

    always #5 clk_out = ~clk_out;

    rd_side_ctrl #(
        .depth     (7),
        .ae_thresh (2)
    ) dut (
        .clk_out       (clk_out),
        .reset         (reset),
        .w2rsync_ff2   (w2rsync_ff2),
        .syn_flush     (syn_flush),
        .rd_req        (rd_req),
        .mem_rd_en     (mem_rd_en),
        .raddr         (raddr),
        .rd_data_valid (rd_data_valid),
        .rptr          (rptr),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_count      (rd_count),
        .flush_ack     (flush_ack),
        .busy_flush    (busy_flush)
    );

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: expected pop address enters the scoreboard as rd_req is driven.
    task automatic cyc(input logic rq, input logic exp_pop, input logic [6:0] addr);
        if (exp_pop) exp_q.push_back(addr);
        rd_req = rq;
        @(negedge clk_out);
        check_eq("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, exp_pop});
        check_eq("rd_data_valid", {31'b0, rd_data_valid}, {31'b0, last_pop});
        if (mem_rd_en && exp_q.size() > 0) begin
            check_eq("raddr", {25'b0, raddr}, {25'b0, exp_q.pop_front()});
        end
        last_pop = exp_pop;
        @(posedge clk_out);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        w2rsync_ff2 = 8'h00;
        syn_flush   = 1'b0;
        rd_req      = 1'b0;
        repeat (3) @(posedge clk_out);
        #1;
        check_eq("rst_rptr", {24'b0, rptr}, 32'h0);
        check_eq("rst_empty", {31'b0, empty}, 32'h1);
        check_eq("rst_ae", {31'b0, almost_empty}, 32'h1);
        check_eq("rst_count", {24'b0, rd_count}, 32'h0);
        check_eq("rst_ack", {31'b0, flush_ack}, 32'h0);
        check_eq("rst_busy", {31'b0, busy_flush}, 32'h0);
        reset = 1'b1;
        @(posedge clk_out);
        #1;
        check_eq("post_rst_rptr", {24'b0, rptr}, 32'h0);
        check_eq("post_rst_empty", {31'b0, empty}, 32'h1);
        check_eq("post_rst_count", {24'b0, rd_count}, 32'h0);

        // Fill to 3 entries and drain with one surplus request.
        w2rsync_ff2 = to_gray(8'd3);
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("fill_empty", {31'b0, empty}, 32'h0);
        check_eq("fill_count", {24'b0, rd_count}, 32'd3);
        check_eq("fill_ae", {31'b0, almost_empty}, 32'h0);
        cyc(1'b1, 1'b1, 7'd0);
        check_eq("drain1_count", {24'b0, rd_count}, 32'd2);
        check_eq("drain1_ae", {31'b0, almost_empty}, 32'h1);
        cyc(1'b1, 1'b1, 7'd1);
        cyc(1'b1, 1'b1, 7'd2);
        check_eq("drain3_empty", {31'b0, empty}, 32'h1);
        check_eq("drain3_rptr", {24'b0, rptr}, 32'h02);
        cyc(1'b1, 1'b0, 7'd0);
        check_eq("ignored_rptr", {24'b0, rptr}, 32'h02);
        check_eq("ignored_count", {24'b0, rd_count}, 32'd0);
        cyc(1'b0, 1'b0, 7'd0);

        // Walk to binary 254, then wrap with occupancy 3.
        w2rsync_ff2 = to_gray(8'd254);
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("walk_count", {24'b0, rd_count}, 32'd251);
        for (int i = 3; i < 254; i++) begin
            logic [7:0] a;
            a = 8'(i);
            cyc(1'b1, 1'b1, a[6:0]);
        end
        check_eq("walk_empty", {31'b0, empty}, 32'h1);
        check_eq("walk_rptr", {24'b0, rptr}, {24'b0, to_gray(8'd254)});
        w2rsync_ff2 = 8'h01;
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("wrap_count", {24'b0, rd_count}, 32'd3);
        cyc(1'b1, 1'b1, 7'd126);
        check_eq("wrap_rptr1", {24'b0, rptr}, 32'h80);
        cyc(1'b1, 1'b1, 7'd127);
        check_eq("wrap_rptr2", {24'b0, rptr}, 32'h00);
        cyc(1'b1, 1'b1, 7'd0);
        check_eq("wrap_rptr3", {24'b0, rptr}, 32'h01);
        check_eq("wrap_empty", {31'b0, empty}, 32'h1);

        // Advance to rbin = 2, then flush with data pending and a pop requested.
        w2rsync_ff2 = to_gray(8'd2);
        cyc(1'b0, 1'b0, 7'd0);
        cyc(1'b1, 1'b1, 7'd1);
        w2rsync_ff2 = to_gray(8'd10);
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("pre_flush_count", {24'b0, rd_count}, 32'd8);
        syn_flush = 1'b1;
        cyc(1'b1, 1'b0, 7'd0);
        check_eq("flush_busy", {31'b0, busy_flush}, 32'h1);
        check_eq("flush_rptr_hold", {24'b0, rptr}, 32'h03);
        cyc(1'b1, 1'b0, 7'd0);
        check_eq("skip_rptr", {24'b0, rptr}, 32'h0F);
        check_eq("skip_empty", {31'b0, empty}, 32'h1);
        check_eq("skip_count", {24'b0, rd_count}, 32'd0);
        check_eq("skip_ae", {31'b0, almost_empty}, 32'h1);
        cyc(1'b1, 1'b0, 7'd0);
        check_eq("ack_high", {31'b0, flush_ack}, 32'h1);
        check_eq("ack_busy", {31'b0, busy_flush}, 32'h1);

        // Write arrives while the acknowledge is held.
        w2rsync_ff2 = to_gray(8'd12);
        cyc(1'b1, 1'b0, 7'd0);
        check_eq("track_rptr", {24'b0, rptr}, 32'h0A);
        check_eq("track_empty", {31'b0, empty}, 32'h1);
        syn_flush = 1'b0;
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("exit_ack", {31'b0, flush_ack}, 32'h0);
        check_eq("exit_busy", {31'b0, busy_flush}, 32'h0);
        check_eq("exit_empty", {31'b0, empty}, 32'h1);
        w2rsync_ff2 = to_gray(8'd13);
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("resume_count", {24'b0, rd_count}, 32'd1);
        check_eq("resume_empty", {31'b0, empty}, 32'h0);
        cyc(1'b1, 1'b1, 7'd12);
        check_eq("resume_pop_empty", {31'b0, empty}, 32'h1);

        // Reset in the middle of a flush, with the request still high at release.
        syn_flush = 1'b1;
        cyc(1'b0, 1'b0, 7'd0);
        cyc(1'b0, 1'b0, 7'd0);
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("mid_ack", {31'b0, flush_ack}, 32'h1);
        reset = 1'b0;
        #1;
        check_eq("async_ack", {31'b0, flush_ack}, 32'h0);
        check_eq("async_busy", {31'b0, busy_flush}, 32'h0);
        check_eq("async_rptr", {24'b0, rptr}, 32'h0);
        @(posedge clk_out);
        #1;
        reset    = 1'b1;
        last_pop = 1'b0;
        @(posedge clk_out);
        #1;
        check_eq("restart_busy", {31'b0, busy_flush}, 32'h1);
        cyc(1'b1, 1'b0, 7'd0);
        check_eq("restart_rptr", {24'b0, rptr}, 32'h0B);
        check_eq("restart_empty", {31'b0, empty}, 32'h1);
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("restart_ack", {31'b0, flush_ack}, 32'h1);
        syn_flush = 1'b0;
        cyc(1'b0, 1'b0, 7'd0);
        check_eq("restart_exit", {31'b0, busy_flush}, 32'h0);

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
